// File: rtl/spi_tick_master.sv
// SPI master that advances one step per rising edge of an external divided tick.
// Frames are WORDLEN bits, MSB first, mode 0; cs_n idles GAP_STEPS steps between frames.
module spi_tick_master #(
  parameter int WORDLEN   = 16,
  parameter int GAP_STEPS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_in,
  input  logic               cmd_valid,
  input  logic [WORDLEN-1:0] cmd_data,
  output logic               cmd_ready,
  output logic               cs_n,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso,
  output logic               rsp_valid,
  output logic [WORDLEN-1:0] rsp_data,
  output logic               busy
);

  localparam int BW = $clog2(WORDLEN);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t             state_q, state_d;
  logic               tick_d, step;
  logic               phase_q, phase_d;
  logic               rdy_q;
  logic [WORDLEN-1:0] tx_q, tx_d, rx_q, rx_d, rsp_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [7:0]         gap_q, gap_d;
  logic               cs_d, sclk_d, mosi_d, rv_d;

  assign step      = tick_in & ~tick_d;
  // rdy_q keeps cmd_ready low until the first edge after reset release
  assign cmd_ready = rdy_q && (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tick_d    <= 1'b0;
      phase_q   <= 1'b0;
      rdy_q     <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state_q   <= state_d;
      tick_d    <= tick_in;
      phase_q   <= phase_d;
      rdy_q     <= 1'b1;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      cs_n      <= cs_d;
      sclk      <= sclk_d;
      mosi      <= mosi_d;
      rsp_valid <= rv_d;
      rsp_data  <= rsp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    cs_d    = cs_n;
    sclk_d  = sclk;
    mosi_d  = mosi;
    rv_d    = 1'b0;
    rsp_d   = rsp_data;
    unique case (state_q)
      IDLE: if (cmd_valid && cmd_ready) begin
        tx_d    = cmd_data;
        rx_d    = '0;
        bit_d   = BW'(WORDLEN-1);
        phase_d = 1'b0;
        cs_d    = 1'b0;
        mosi_d  = cmd_data[WORDLEN-1];
        state_d = SETUP;
      end
      SETUP: if (step) begin
        phase_d = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: if (step) begin
        if (!phase_q) begin
          sclk_d  = 1'b1;
          rx_d    = {rx_q[WORDLEN-2:0], miso};
          phase_d = 1'b1;
        end else begin
          sclk_d  = 1'b0;
          phase_d = 1'b0;
          if (bit_q != '0) begin
            bit_d  = bit_q - BW'(1);
            tx_d   = tx_q << 1;
            mosi_d = tx_q[WORDLEN-2];
          end else begin
            // last fall: park mosi low so it is already quiet through HOLD/GAP
            mosi_d  = 1'b0;
            state_d = HOLD;
          end
        end
      end
      HOLD: if (step) begin
        cs_d    = 1'b1;
        rsp_d   = rx_q;
        rv_d    = 1'b1;
        gap_d   = 8'(GAP_STEPS);
        state_d = GAP;
      end
      GAP: if (step) begin
        gap_d = gap_q - 8'd1;
        if (gap_q == 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_tick_master.sv
// Directed bench for spi_tick_master: frame table plus reset, stall, back-to-back and ignore cases.
module tb_spi_tick_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_in = 1'b0;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        cmd_ready, cs_n, sclk, mosi, miso, rsp_valid, busy;
  logic [15:0] rsp_data;

  int miso_mode = 0;  // 0: loop mosi, 1: tie high, 2: tie low
  bit tick_run  = 1'b0;
  int ph        = 0;

  int errors = 0;
  int checks = 0;

  // monitor state
  int n_sclk = 0, n_rsp = 0, n_step = 0, n_busy = 0, n_mone = 0;
  int n_csh = 0, n_rdy = 0, n_mbad = 0, n_sbad = 0, n_mglitch = 0;
  logic [15:0] last_rsp = '0;
  bit tick_last = 0, busy_last = 0, sclk_last = 0, mosi_last = 0, cs_last = 1, rst_last = 0;

  assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1);

  spi_tick_master #(.WORDLEN(16), .GAP_STEPS(2)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Negedge: sample DUT outputs, then advance tick_in (period 6 clk, toggles every 3)
  always @(negedge clk) begin
    if (tick_in && !tick_last && busy_last) n_step <= n_step + 1;
    if (busy) n_busy <= n_busy + 1;
    if (sclk && !sclk_last) n_sclk <= n_sclk + 1;
    if (rsp_valid) begin n_rsp <= n_rsp + 1; last_rsp <= rsp_data; end
    if (mosi) n_mone <= n_mone + 1;
    if (cs_n) n_csh <= n_csh + 1;
    if (cmd_ready) n_rdy <= n_rdy + 1;
    if (cs_n && mosi) n_mbad <= n_mbad + 1;
    if (cs_n && sclk) n_sbad <= n_sbad + 1;
    if (reset && rst_last && (mosi != mosi_last) && !(sclk_last && !sclk) && !(cs_last && !cs_n))
      n_mglitch <= n_mglitch + 1;
    tick_last <= tick_in;
    busy_last <= busy;
    sclk_last <= sclk;
    mosi_last <= mosi;
    cs_last   <= cs_n;
    rst_last  <= reset;
    if (tick_run) begin
      ph      <= (ph == 5) ? 0 : ph + 1;
      tick_in <= (ph == 2 || ph == 3 || ph == 4);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer a one-clk command timed to coincide with a step edge
  task automatic start_cmd(input logic [15:0] d);
    int t = 0;
    do begin @(posedge clk); #1; t++; end while (ph != 2 && t < 20);
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 5000) begin @(posedge clk); #1; t++; end
    chk({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic frame_chk(input string name, input logic [15:0] d, input int mode,
                           input logic [15:0] exp, input bit mzero);
    int s_sclk, s_rsp, s_step, s_busy, s_mone;
    miso_mode = mode;
    s_sclk = n_sclk; s_rsp = n_rsp; s_step = n_step; s_busy = n_busy; s_mone = n_mone;
    start_cmd(d);
    wait_idle(name);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_sclk_pulses"}, n_sclk - s_sclk, 32'd16);
    chk({name, "_rsp_count"}, n_rsp - s_rsp, 32'd1);
    chk({name, "_rsp_data"}, 32'(last_rsp), 32'(exp));
    chk({name, "_rsp_hold"}, 32'(rsp_data), 32'(exp));
    chk({name, "_steps"}, n_step - s_step, 32'd36);
    chk({name, "_busy_clk"}, n_busy - s_busy, 32'd216);
    if (mzero) chk({name, "_mosi_ones"}, n_mone - s_mone, 32'd0);
  endtask

  typedef struct {
    logic [15:0] data;
    int          mode;
    logic [15:0] rsp;
    bit          mzero;
  } vec_t;

  vec_t vt[5];

  initial begin
    int t, k, bad, s_rsp, s_step, s_sclk, s_busy, s_csh, s_rdy;
    vt[0] = '{16'hA5C3, 0, 16'hA5C3, 1'b0};
    vt[1] = '{16'h0000, 1, 16'hFFFF, 1'b1};
    vt[2] = '{16'hFFFF, 2, 16'h0000, 1'b0};
    vt[3] = '{16'h8001, 0, 16'h8001, 1'b0};
    vt[4] = '{16'h1234, 1, 16'hFFFF, 1'b0};

    reset = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    tick_run = 1'b1;
    repeat (12) @(posedge clk);

    for (int i = 0; i < 5; i++) frame_chk($sformatf("vec%0d", i), vt[i].data, vt[i].mode, vt[i].rsp, vt[i].mzero);

    // Back-to-back frames with cmd_valid held high
    miso_mode = 0; cmd_data = 16'h5AA5; cmd_valid = 1'b1;
    k = 0; t = 0;
    while (k < 1 && t < 1000) begin @(posedge clk); #1; t++; if (rsp_valid) k++; end
    s_csh = n_csh; s_rdy = n_rdy;
    while (k < 3 && t < 3000) begin @(posedge clk); #1; t++; if (rsp_valid) k++; end
    chk("b2b_last_rsp", 32'(rsp_data), 32'h5AA5);
    cmd_valid = 1'b0;
    chk("b2b_frames", k, 32'd3);
    chk("b2b_cs_high_clk", n_csh - s_csh, 32'd26);
    chk("b2b_ready_clk", n_rdy - s_rdy, 32'd2);
    wait_idle("b2b");
    s_busy = n_busy;
    repeat (50) @(posedge clk);
    #1;
    chk("b2b_no_extra", n_busy - s_busy, 32'd0);

    // Reset asserted mid-frame at step 10
    miso_mode = 0; s_rsp = n_rsp; s_step = n_step;
    start_cmd(16'h3C5A);
    t = 0;
    while (n_step - s_step < 10 && t < 500) begin @(posedge clk); #1; t++; end
    chk("abort_sclk_before", 32'(sclk), 32'd1);
    reset = 1'b0; #1;
    chk("abort_cs_n", 32'(cs_n), 32'd1);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rsp_data", 32'(rsp_data), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_no_rsp", n_rsp - s_rsp, 32'd0);
    frame_chk("after_abort", 16'hC3A5, 0, 16'hC3A5, 1'b0);

    // tick_in stuck high right after the SETUP step
    miso_mode = 0; s_rsp = n_rsp; s_step = n_step; s_sclk = n_sclk;
    start_cmd(16'hC0DE);
    t = 0;
    while (n_step - s_step < 1 && t < 100) begin @(posedge clk); #1; t++; end
    tick_run = 1'b0;
    bad = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (!(cs_n == 1'b0 && sclk == 1'b0 && busy == 1'b1 && tick_in == 1'b1)) bad++;
    end
    chk("stall_hold", bad, 32'd0);
    tick_run = 1'b1;
    wait_idle("stall");
    repeat (2) @(posedge clk);
    #1;
    chk("stall_rsp_count", n_rsp - s_rsp, 32'd1);
    chk("stall_rsp_data", 32'(last_rsp), 32'hC0DE);
    chk("stall_sclk_pulses", n_sclk - s_sclk, 32'd16);

    // cmd_valid pulsed mid-frame is ignored
    miso_mode = 0; s_rsp = n_rsp; s_sclk = n_sclk;
    start_cmd(16'h1357);
    repeat (40) @(posedge clk);
    #1;
    cmd_data = 16'hFFFF; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle("ignore");
    s_busy = n_busy;
    repeat (100) @(posedge clk);
    #1;
    chk("ignore_no_frame", n_busy - s_busy, 32'd0);
    chk("ignore_rsp_count", n_rsp - s_rsp, 32'd1);
    chk("ignore_rsp_data", 32'(last_rsp), 32'h1357);
    chk("ignore_sclk_pulses", n_sclk - s_sclk, 32'd16);

    chk("mosi_while_cs_high", n_mbad, 32'd0);
    chk("sclk_while_cs_high", n_sbad, 32'd0);
    chk("mosi_change_timing", n_mglitch, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
